wb_stage: RTL and testbench

//  Writeback stage directly upstream of the register file. Accepts retiring ops

---
 rtl/cpu_pkg.sv | 16 +
 rtl/wb_hazard_cmp.sv | 30 +++
 rtl/wb_stage.sv | 132 +++++++++++++
 tb/tb_wb_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback FSM states, hard-zero register, default
// datapath widths and the data-memory load timeout.
package cpu_pkg;

  localparam int W_DEF       = 8;
  localparam int D_DEF       = 4;
  localparam int ZERO_REG    = 15;
  localparam int MEM_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WRITE
  } wb_state_t;

endpackage

// File: rtl/wb_hazard_cmp.sv
// One register-file read port checked against the writeback stage's pending
// destination. Build option WB_FWD_EN turns WRITE-state matches into forwards.
module wb_hazard_cmp import cpu_pkg::*; #(
  parameter int D        = D_DEF,
  parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
  input  logic [D-1:0] i_src,
  input  logic [D-1:0] i_pendDest,
  input  logic         i_waitMem,
  input  logic         i_writeActive,
  output logic         o_hazard
`ifdef WB_FWD_EN
  ,
  output logic         o_fwd
`endif
);

  logic w_match;

  // The hard-zero register never carries a pending value, so it never conflicts.
  assign w_match = (i_src == i_pendDest) && (i_src != D'(ZERO_REG));

`ifdef WB_FWD_EN
  assign o_hazard = w_match & i_waitMem;
  assign o_fwd    = w_match & i_writeActive;
`else
  assign o_hazard = w_match & (i_waitMem | i_writeActive);
`endif

endmodule

// File: rtl/wb_stage.sv
// Writeback stage feeding the register file write port, with load wait and
// timeout. Optional operand forwarding is enabled by defining WB_FWD_EN.
module wb_stage import cpu_pkg::*; #(
  parameter int W           = W_DEF,
  parameter int D           = D_DEF,
  parameter int ZERO_REG    = cpu_pkg::ZERO_REG,
  parameter int MEM_TIMEOUT = cpu_pkg::MEM_TIMEOUT
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         ex_valid,
  output logic         ex_ready,
  input  logic         ex_wen,
  input  logic         ex_is_load,
  input  logic [D-1:0] ex_dest,
  input  logic [W-1:0] ex_result,
  input  logic         mem_rvalid,
  input  logic [W-1:0] mem_rdata,
  input  logic [D-1:0] srcA,
  input  logic [D-1:0] srcB,
  output logic         hazardA,
  output logic         hazardB,
  output logic         RegWrite,
  output logic [D-1:0] writeReg,
  output logic [W-1:0] writeValue,
  output logic         err_timeout
`ifdef WB_FWD_EN
  ,
  output logic         fwdA,
  output logic         fwdB,
  output logic [W-1:0] fwd_value
`endif
);

  localparam int             CW   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [D-1:0]   ZR   = D'(ZERO_REG);
  localparam logic [CW-1:0]  LAST = CW'(MEM_TIMEOUT - 1);

  wb_state_t     r_state;
  logic [CW-1:0] r_count;
  logic [D-1:0]  r_pendDest;
  logic          w_waitMem;
  logic          w_writeActive;

  assign ex_ready      = (r_state != WAIT_MEM);
  assign w_waitMem     = (r_state == WAIT_MEM);
  assign w_writeActive = (r_state == WRITE) && RegWrite;

  // writeReg/writeValue only move together with a RegWrite pulse, so the write
  // port looks stable to the register file whenever it is idle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_pendDest  <= '0;
      RegWrite    <= 1'b0;
      writeReg    <= '0;
      writeValue  <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE, WRITE: begin
          RegWrite <= 1'b0;
          r_state  <= IDLE;
          if (ex_valid && ex_wen) begin
            r_pendDest <= ex_dest;
            if (ex_is_load) begin
              r_count <= '0;
              r_state <= WAIT_MEM;
            end else begin
              r_state <= WRITE;
              if (ex_dest != ZR) begin
                RegWrite   <= 1'b1;
                writeReg   <= ex_dest;
                writeValue <= ex_result;
              end
            end
          end
        end
        WAIT_MEM: begin
          RegWrite <= 1'b0;
          if (mem_rvalid) begin
            r_state <= WRITE;
            if (r_pendDest != ZR) begin
              RegWrite   <= 1'b1;
              writeReg   <= r_pendDest;
              writeValue <= mem_rdata;
            end
          end else if (r_count == LAST) begin
            err_timeout <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        default: begin
          RegWrite <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  wb_hazard_cmp #(.D(D), .ZERO_REG(ZERO_REG)) u_cmpA (
    .i_src         (srcA),
    .i_pendDest    (r_pendDest),
    .i_waitMem     (w_waitMem),
    .i_writeActive (w_writeActive),
    .o_hazard      (hazardA)
`ifdef WB_FWD_EN
    ,
    .o_fwd         (fwdA)
`endif
  );

  wb_hazard_cmp #(.D(D), .ZERO_REG(ZERO_REG)) u_cmpB (
    .i_src         (srcB),
    .i_pendDest    (r_pendDest),
    .i_waitMem     (w_waitMem),
    .i_writeActive (w_writeActive),
    .o_hazard      (hazardB)
`ifdef WB_FWD_EN
    ,
    .o_fwd         (fwdB)
`endif
  );

`ifdef WB_FWD_EN
  assign fwd_value = writeValue;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, hand-written load,
// timeout and reset sequences, then randomized traffic against a reference model.
module tb_wb_stage;

  localparam int MEM_TIMEOUT = 16;
  localparam logic [3:0] ZR = 4'd15;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       ex_valid, ex_ready, ex_wen, ex_is_load;
  logic [3:0] ex_dest;
  logic [7:0] ex_result;
  logic       mem_rvalid;
  logic [7:0] mem_rdata;
  logic [3:0] srcA, srcB;
  logic       hazardA, hazardB, RegWrite, err_timeout;
  logic [3:0] writeReg;
  logic [7:0] writeValue;
`ifdef WB_FWD_EN
  logic       fwdA, fwdB;
  logic [7:0] fwd_value;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] rf [16] = '{default: 8'h00};

  always #5 CLK = ~CLK;

  // Register file model sitting on the write port.
  always @(posedge CLK) if (RegWrite) rf[writeReg] <= writeValue;

  wb_stage dut (
    .CLK(CLK), .RSTn(RSTn),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
    .ex_dest(ex_dest), .ex_result(ex_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .srcA(srcA), .srcB(srcB), .hazardA(hazardA), .hazardB(hazardB),
    .RegWrite(RegWrite), .writeReg(writeReg), .writeValue(writeValue),
    .err_timeout(err_timeout)
`ifdef WB_FWD_EN
    , .fwdA(fwdA), .fwdB(fwdB), .fwd_value(fwd_value)
`endif
  );

  typedef struct {
    logic       valid, wen, isLoad;
    logic [3:0] dest;
    logic [7:0] result;
    logic [3:0] sA, sB;
    logic       expReady, expRW;
    logic [3:0] expWR;
    logic [7:0] expWV;
    logic       expHazA, expHazB;
  } vec_t;

  vec_t tbl [8];

  // Reference model state: an outstanding load and the write currently on the port.
  logic       mPending;
  logic [3:0] mLoadDest;
  int         mWaited;
  logic       mRW;
  logic [3:0] mWR;
  logic [7:0] mWV;
  logic       mErr;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    ex_valid   = v.valid;
    ex_wen     = v.wen;
    ex_is_load = v.isLoad;
    ex_dest    = v.dest;
    ex_result  = v.result;
    mem_rvalid = 1'b0;
    mem_rdata  = 8'h00;
    srcA       = v.sA;
    srcB       = v.sB;
  endtask

  task automatic idleInputs();
    ex_valid = 1'b0; ex_wen = 1'b0; ex_is_load = 1'b0; ex_dest = 4'd0; ex_result = 8'h00;
    mem_rvalid = 1'b0; mem_rdata = 8'h00; srcA = 4'd0; srcB = 4'd0;
  endtask

  task automatic issue(input logic load, input logic [3:0] dest, input logic [7:0] res);
    ex_valid = 1'b1; ex_wen = 1'b1; ex_is_load = load; ex_dest = dest; ex_result = res;
  endtask

  task automatic modelReset();
    mPending = 1'b0; mLoadDest = 4'd0; mWaited = 0;
    mRW = 1'b0; mWR = 4'd0; mWV = 8'h00; mErr = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs held during the cycle.
  task automatic modelEdge();
    mRW = 1'b0;
    if (mPending) begin
      if (mem_rvalid) begin
        mPending = 1'b0;
        if (mLoadDest != ZR) begin mRW = 1'b1; mWR = mLoadDest; mWV = mem_rdata; end
      end else if (mWaited + 1 == MEM_TIMEOUT) begin
        mPending = 1'b0;
        mErr     = 1'b1;
      end else begin
        mWaited++;
      end
    end else if (ex_valid && ex_wen) begin
      if (ex_is_load) begin
        mPending = 1'b1; mWaited = 0; mLoadDest = ex_dest;
      end else if (ex_dest != ZR) begin
        mRW = 1'b1; mWR = ex_dest; mWV = ex_result;
      end
    end
  endtask

  // Returns {forward, hazard} expected for one read address.
  function automatic logic [1:0] expRead(input logic [3:0] src);
    logic loadHit, writeHit;
    loadHit  = mPending && (src == mLoadDest) && (src != ZR);
    writeHit = mRW && (src == mWR) && (src != ZR);
`ifdef WB_FWD_EN
    return {writeHit, loadHit};
`else
    return {1'b0, loadHit | writeHit};
`endif
  endfunction

  function automatic logic [3:0] pickReg();
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return mLoadDest;
    if (r == 1) return mWR;
    if (r == 2) return ZR;
    return 4'($urandom_range(0, 7));
  endfunction

  task automatic checkModel();
    logic [1:0] eA, eB;
    eA = expRead(srcA);
    eB = expRead(srcB);
    checkOutput("rnd_ex_ready", 32'(ex_ready), 32'(!mPending));
    checkOutput("rnd_RegWrite", 32'(RegWrite), 32'(mRW));
    checkOutput("rnd_writeReg", 32'(writeReg), 32'(mWR));
    checkOutput("rnd_writeValue", 32'(writeValue), 32'(mWV));
    checkOutput("rnd_err_timeout", 32'(err_timeout), 32'(mErr));
    checkOutput("rnd_hazardA", 32'(hazardA), 32'(eA[0]));
    checkOutput("rnd_hazardB", 32'(hazardB), 32'(eB[0]));
`ifdef WB_FWD_EN
    checkOutput("rnd_fwdA", 32'(fwdA), 32'(eA[1]));
    checkOutput("rnd_fwdB", 32'(fwdB), 32'(eB[1]));
    if (eA[1] || eB[1]) checkOutput("rnd_fwd_value", 32'(fwd_value), 32'(mWV));
`endif
  endtask

  initial begin
    // valid wen load dest result srcA srcB | ready RW WR WV hazA hazB
    tbl[0] = '{1'b1, 1'b1, 1'b0, 4'd3,  8'h5A, 4'd0,  4'd0,  1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 4'd1,  8'h11, 4'd3,  4'd1,  1'b1, 1'b1, 4'd3, 8'h5A, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 4'd2,  8'h22, 4'd1,  4'd3,  1'b1, 1'b1, 4'd1, 8'h11, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 4'd4,  8'h44, 4'd0,  4'd2,  1'b1, 1'b1, 4'd2, 8'h22, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 4'd15, 8'hFF, 4'd4,  4'd15, 1'b1, 1'b1, 4'd4, 8'h44, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 4'd0,  8'h00, 4'd15, 4'd4,  1'b1, 1'b0, 4'd4, 8'h44, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 4'd9,  8'h99, 4'd9,  4'd4,  1'b1, 1'b0, 4'd4, 8'h44, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 4'd9,  4'd0,  1'b1, 1'b0, 4'd4, 8'h44, 1'b0, 1'b0};

    RSTn = 1'b0;
    idleInputs();
    tick();
    tick();
    checkOutput("reset_RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("reset_writeReg", 32'(writeReg), 32'd0);
    checkOutput("reset_writeValue", 32'(writeValue), 32'd0);
    checkOutput("reset_err", 32'(err_timeout), 32'd0);
    checkOutput("reset_ready", 32'(ex_ready), 32'd1);
    RSTn = 1'b1;
    tick();

    // ALU writes, back-to-back, zero register and a non-writing op.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i]);
      #4;
      checkOutput($sformatf("tbl%0d_ready", i), 32'(ex_ready), 32'(tbl[i].expReady));
      checkOutput($sformatf("tbl%0d_RegWrite", i), 32'(RegWrite), 32'(tbl[i].expRW));
      checkOutput($sformatf("tbl%0d_writeReg", i), 32'(writeReg), 32'(tbl[i].expWR));
      checkOutput($sformatf("tbl%0d_writeValue", i), 32'(writeValue), 32'(tbl[i].expWV));
`ifdef WB_FWD_EN
      checkOutput($sformatf("tbl%0d_hazardA", i), 32'(hazardA), 32'd0);
      checkOutput($sformatf("tbl%0d_hazardB", i), 32'(hazardB), 32'd0);
      checkOutput($sformatf("tbl%0d_fwdA", i), 32'(fwdA), 32'(tbl[i].expHazA));
      checkOutput($sformatf("tbl%0d_fwdB", i), 32'(fwdB), 32'(tbl[i].expHazB));
      if (tbl[i].expHazA || tbl[i].expHazB)
        checkOutput($sformatf("tbl%0d_fwd_value", i), 32'(fwd_value), 32'(tbl[i].expWV));
`else
      checkOutput($sformatf("tbl%0d_hazardA", i), 32'(hazardA), 32'(tbl[i].expHazA));
      checkOutput($sformatf("tbl%0d_hazardB", i), 32'(hazardB), 32'(tbl[i].expHazB));
`endif
      tick();
    end
    checkOutput("rf3", 32'(rf[3]), 32'h5A);
    checkOutput("rf1", 32'(rf[1]), 32'h11);
    checkOutput("rf2", 32'(rf[2]), 32'h22);
    checkOutput("rf4", 32'(rf[4]), 32'h44);
    checkOutput("rf15", 32'(rf[15]), 32'h00);
    checkOutput("rf9", 32'(rf[9]), 32'h00);

    // Load to r6, data on the 4th wait cycle; stray rvalid while idle is ignored.
    idleInputs();
    issue(1'b1, 4'd6, 8'h00);
    mem_rvalid = 1'b1; mem_rdata = 8'hEE; srcA = 4'd6;
    #4;
    checkOutput("ld_accept_ready", 32'(ex_ready), 32'd1);
    checkOutput("ld_accept_hazA", 32'(hazardA), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 4'd9, 8'h99);
      mem_rvalid = (i == 3); mem_rdata = 8'hC3;
      #4;
      checkOutput($sformatf("ld_wait%0d_ready", i), 32'(ex_ready), 32'd0);
      checkOutput($sformatf("ld_wait%0d_hazA", i), 32'(hazardA), 32'd1);
      checkOutput($sformatf("ld_wait%0d_RegWrite", i), 32'(RegWrite), 32'd0);
      tick();
    end
    ex_valid = 1'b0; mem_rvalid = 1'b0;
    #4;
    checkOutput("ld_RegWrite", 32'(RegWrite), 32'd1);
    checkOutput("ld_writeReg", 32'(writeReg), 32'd6);
    checkOutput("ld_writeValue", 32'(writeValue), 32'hC3);
`ifdef WB_FWD_EN
    checkOutput("ld_write_hazA", 32'(hazardA), 32'd0);
    checkOutput("ld_write_fwdA", 32'(fwdA), 32'd1);
    checkOutput("ld_write_fwd_value", 32'(fwd_value), 32'hC3);
`else
    checkOutput("ld_write_hazA", 32'(hazardA), 32'd1);
`endif
    tick();
    #4;
    checkOutput("ld_after_RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("ld_rf6", 32'(rf[6]), 32'hC3);
    checkOutput("ld_rf9", 32'(rf[9]), 32'h00);
    tick();

    // Load to r7 that never gets data: abandoned after MEM_TIMEOUT wait cycles.
    idleInputs();
    issue(1'b1, 4'd7, 8'h00);
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #4;
      checkOutput($sformatf("to_wait%0d_ready", i), 32'(ex_ready), 32'd0);
      checkOutput($sformatf("to_wait%0d_RegWrite", i), 32'(RegWrite), 32'd0);
      checkOutput($sformatf("to_wait%0d_err", i), 32'(err_timeout), 32'd0);
      tick();
    end
    #4;
    checkOutput("to_err", 32'(err_timeout), 32'd1);
    checkOutput("to_ready", 32'(ex_ready), 32'd1);
    checkOutput("to_RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("to_rf7", 32'(rf[7]), 32'h00);
    RSTn = 1'b0;
    #1;
    checkOutput("to_reset_err", 32'(err_timeout), 32'd0);
    tick();
    RSTn = 1'b1;
    tick();

    // Load to r8 whose data arrives on the very last allowed wait cycle.
    issue(1'b1, 4'd8, 8'h00);
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      mem_rvalid = (i == MEM_TIMEOUT - 1); mem_rdata = 8'h3C;
      #4;
      checkOutput($sformatf("last_wait%0d_ready", i), 32'(ex_ready), 32'd0);
      tick();
    end
    mem_rvalid = 1'b0;
    #4;
    checkOutput("last_RegWrite", 32'(RegWrite), 32'd1);
    checkOutput("last_writeReg", 32'(writeReg), 32'd8);
    checkOutput("last_writeValue", 32'(writeValue), 32'h3C);
    checkOutput("last_err", 32'(err_timeout), 32'd0);
    tick();

    // Reset in the middle of a load to r5, then late data must not be written.
    issue(1'b1, 4'd5, 8'h00);
    srcA = 4'd5;
    tick();
    ex_valid = 1'b0;
    tick();
    tick();
    RSTn = 1'b0;
    #1;
    checkOutput("rst_mid_RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("rst_mid_writeReg", 32'(writeReg), 32'd0);
    checkOutput("rst_mid_writeValue", 32'(writeValue), 32'd0);
    checkOutput("rst_mid_err", 32'(err_timeout), 32'd0);
    checkOutput("rst_mid_ready", 32'(ex_ready), 32'd1);
    checkOutput("rst_mid_hazA", 32'(hazardA), 32'd0);
    tick();
    RSTn = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 8'h77;
    for (int i = 0; i < 2; i++) begin
      #4;
      checkOutput($sformatf("rst_late%0d_RegWrite", i), 32'(RegWrite), 32'd0);
      tick();
    end
    #4;
    checkOutput("rst_late_RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("rst_rf5", 32'(rf[5]), 32'h00);
    tick();

    // Randomized traffic with occasional resets, checked against the model.
    idleInputs();
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    modelReset();
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        RSTn = 1'b0;
        #1;
        modelReset();
        checkModel();
        tick();
        RSTn = 1'b1;
      end else begin
        ex_valid   = ($urandom_range(0, 1) == 1);
        ex_wen     = ($urandom_range(0, 4) != 0);
        ex_is_load = ($urandom_range(0, 2) == 0);
        ex_dest    = pickReg();
        ex_result  = 8'($urandom);
        mem_rvalid = ($urandom_range(0, 5) == 0);
        mem_rdata  = 8'($urandom);
        srcA       = pickReg();
        srcB       = pickReg();
        #4;
        checkModel();
        @(posedge CLK);
        modelEdge();
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
